uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised RS-232 transmitter with an input FIFO, for the measurement result/debug path.
//  Frame format is set at elaboration: data width, parity and stop bits.
//  Accepts words on a valid/ready interface, buffers them, and serialises back-to-back frames LSB-first on txd.
// PARAMETERS
//  CLK_FREQ    100000000  clk frequency in Hz
//  BAUD        38400      line rate in bit/s; requires CLK_FREQ >= 8*BAUD (elaboration error otherwise)
//  DATA_BITS   8          payload bits per frame, 5..9
//  PARITY      0          0 = none, 1 = odd, 2 = even
//  STOP_BITS   2          1 or 2
//  FIFO_DEPTH  16         FIFO entries; power of 2, >= 2
// PORTS
//  clk         in   1                       system clock
//  rst_n       in   1                       asynchronous active-low reset
//  wr_valid    in   1                       wr_data is valid
//  wr_ready    out  1                       FIFO can accept a word
//  wr_data     in   DATA_BITS               word to send
//  txd         out  1                       serial line; idles high
//  busy        out  1                       frame in progress, or FIFO not empty
//  fifo_level  out  $clog2(FIFO_DEPTH)+1    number of words currently held in the FIFO
//  cts_n       in   1                       clear-to-send, active low; present only with UART_TX_CTS_EN
// BEHAVIOUR
//  Reset (async assert, sync release): txd=1, busy=0, wr_ready=1, fifo_level=0, FSM in IDLE.
//   FIFO pointers are cleared. Asserting reset mid-frame drives txd high at once; the frame is lost.
//  Handshake: a write happens on a rising edge with wr_valid & wr_ready.
//   wr_ready = ~full, and does not depend on a pop in the same cycle.
//   wr_valid while full is ignored; no data is lost because the word is never accepted.
//  Baud tick (one tick per bit time): phase accumulator.
//   ACC_W = clog2(CLK_FREQ/BAUD) + 8.
//   INC = round((BAUD << ACC_W) / CLK_FREQ), computed in 64-bit arithmetic.
//   Accumulator is loaded with 0 in IDLE; tick = carry out of bit ACC_W.
//   Accumulated error is < 2% per frame.
//  FSM: IDLE -> START -> DATA -> [PAR] -> STOP -> IDLE, or STOP -> START when the FIFO is not empty.
//   IDLE: if FIFO not empty, pop into the shift register and go to START.
//    Pop and write in the same cycle are both honoured; fifo_level is unchanged.
//   START: txd=0 for 1 bit time.
//   DATA: txd = shift[0]; shift right on each tick. The bit counter runs 0..DATA_BITS-1.
//   PAR: entered only if PARITY != 0. txd = ^word for even, ~^word for odd; parity is computed at pop time.
//   STOP: txd=1 for STOP_BITS bit times.
//    At the end, if FIFO not empty (and CTS allows), pop and go directly to START with no idle gap.
//  Latency: write into an idle, empty block drives txd low on the 2nd rising edge after the write edge.
//  busy = (state != IDLE) | ~empty. It falls in the cycle after the last stop bit ends with an empty FIFO.
//  fifo_level wraps never; its maximum value is FIFO_DEPTH.
// CONFIGURATION
//  UART_TX_CTS_EN defined:
//   - cts_n port exists and is synchronised through 2 flops.
//   - A new frame (IDLE pop, or STOP->START) starts only when synced cts_n = 0.
//   - A frame in flight always completes.
//   - While blocked, txd=1 and busy=1 if the FIFO is not empty.
//  UART_TX_CTS_EN undefined: no cts_n port; frames start whenever the FIFO is not empty.
// STRUCTURE
//  Package uart_pkg:
//   - parity localparams PAR_NONE/PAR_ODD/PAR_EVEN
//   - FSM state encoding (IDLE/START/DATA/PAR/STOP)
//   - function clog2
//   - function baud_inc(clk_freq, baud, acc_w)
//  Sub-module uart_baud_tick (clk, rst_n, en, tick) with params CLK_FREQ, BAUD.
//   This is the phase accumulator; clear when en=0.
//  FIFO: inline register array, pointers one bit wider than the address for full/empty detection.
// TESTING
//  Common settings: CLK_FREQ=1000000, BAUD=100000, so one bit time ~= 10 clk.
//  1. 8N1, write 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); each bit 10+-1 clk; busy drops after the stop bit.
//  2. 7E2, write 0x41 (two bits set, even) -> parity bit 0 after the 7 data bits, then 2 stop bits; 0x43 -> parity bit 1.
//  3. DEPTH=4, 6 writes while wr_valid is held -> wr_ready=0 at level 4; all 6 frames arrive in order, back-to-back, with no idle bit between stop and start.
//  4. rst_n pulled low during data bit 3 -> txd=1 within the same cycle; level=0; after release, a new write is sent correctly.
//  5. Write in the same cycle as a STOP->START pop with level=2 -> level stays 2 and the word is not dropped.
//  6. With UART_TX_CTS_EN, cts_n=1, write 0x55 -> txd stays 1 and busy=1; cts_n=0 -> start bit begins 3-4 clk later; toggling cts_n mid-frame does not truncate the frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity modes, FSM encoding
// and the elaboration-time helpers used to size the baud accumulator.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    // Ceiling log2; values 0 and 1 both return 0.
    function automatic int clog2(input longint unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Rounded phase increment so that the accumulator overflows once per bit time.
    function automatic longint unsigned baud_inc(input longint unsigned clk_freq,
                                                 input longint unsigned baud,
                                                 input int              acc_w);
        return ((baud << acc_w) + (clk_freq >> 1)) / clk_freq;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Phase-accumulator bit-time generator: one-cycle tick per bit period while en
// is high; the accumulator restarts from zero whenever en is low.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 38400
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int              ACC_W = clog2(64'(CLK_FREQ / BAUD)) + 8;
    localparam longint unsigned INC_L = baud_inc(64'(CLK_FREQ), 64'(BAUD), ACC_W);
    localparam logic [ACC_W:0]  INC   = INC_L[ACC_W:0];

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + INC;
        acc_d = en ? sum[ACC_W-1:0] : '0;
        tick  = en & sum[ACC_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered RS-232 transmitter: valid/ready write port into a FIFO, frames sent
// back-to-back LSB-first. Define UART_TX_CTS_EN to add cts_n flow control.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 38400,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wr_valid,
    output logic                                  wr_ready,
    input  logic [DATA_BITS-1:0]                  wr_data,
    output logic                                  txd,
    output logic                                  busy,
    output logic [clog2(64'(FIFO_DEPTH)):0]       fifo_level
`ifdef UART_TX_CTS_EN
    ,
    input  logic                                  cts_n
`endif
);

    localparam int AW = clog2(64'(FIFO_DEPTH));
    localparam int CW = clog2(64'(DATA_BITS + 1));

    if (CLK_FREQ < 8 * BAUD) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_FREQ must be at least 8*BAUD");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end

    // FIFO: pointers carry one extra wrap bit so full and empty are distinct.
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]          level;
    logic                 full, empty, push, pop;
    logic [DATA_BITS-1:0] head;

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        full     = (level == (AW + 1)'(FIFO_DEPTH));
        empty    = (level == '0);
        wr_ready = ~full;
        push     = wr_valid & ~full;
        head     = fifo_mem[rd_ptr_q[AW-1:0]];
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign fifo_level = level;

    // Flow control: a new frame may only start while the synchronised cts_n is low.
    logic cts_ok;
`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync_q, cts_sync_d;
    always_comb cts_sync_d = {cts_sync_q[0], cts_n};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cts_sync_q <= 2'b11;
        else        cts_sync_q <= cts_sync_d;
    end
    assign cts_ok = ~cts_sync_q[1];
`else
    assign cts_ok = 1'b1;
`endif

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 tick, start_ok, head_par;

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q != IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            txd_q     <= txd_d;
        end
    end

    always_comb begin
        start_ok  = ~empty & cts_ok;
        head_par  = (PARITY == PAR_EVEN) ? ^head : ~^head;
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = head_par;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == CW'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        // Chain straight into the next start bit with no idle gap.
                        if (start_ok) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = head_par;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // txd is registered, so the line trails the state register by one clock.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            PAR:     txd_d = par_q;
            default: txd_d = 1'b1;
        endcase
    end

    assign txd  = txd_q;
    assign busy = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8N1 depth-16 instance and a 7E2 depth-4
// instance share one clock; received frames are scored against an expected queue.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic clk;
  logic rst_a_n, rst_b_n;

  logic       wr_valid_a, wr_ready_a, txd_a, busy_a;
  logic [7:0] wr_data_a;
  logic [4:0] level_a;

  logic       wr_valid_b, wr_ready_b, txd_b, busy_b;
  logic [6:0] wr_data_b;
  logic [2:0] level_b;

`ifdef UART_TX_CTS_EN
  logic cts_n_a;
`endif

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  uart_tx_fifo #(
    .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_a_n), .wr_valid(wr_valid_a), .wr_ready(wr_ready_a),
    .wr_data(wr_data_a), .txd(txd_a), .busy(busy_a), .fifo_level(level_a)
`ifdef UART_TX_CTS_EN
    , .cts_n(cts_n_a)
`endif
  );

  uart_tx_fifo #(
    .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
    .wr_data(wr_data_b), .txd(txd_b), .busy(busy_b), .fifo_level(level_b)
`ifdef UART_TX_CTS_EN
    , .cts_n(1'b0)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic logic txd_of(input int sel);
    return (sel != 0) ? txd_b : txd_a;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  // Driver: called at a negedge, returns at the negedge after the accepting edge.
  task automatic write_word(input int sel, input logic [8:0] data, input bit track);
    logic rdy;
    int n;
    n = 0;
    if (sel == 0) begin
      wr_valid_a = 1'b1; wr_data_a = data[7:0];
    end else begin
      wr_valid_b = 1'b1; wr_data_b = data[6:0];
    end
    do begin
      rdy = (sel != 0) ? wr_ready_b : wr_ready_a;
      @(posedge clk);
      n++;
      if (!rdy) @(negedge clk);
    end while (!rdy && n < 3000);
    check("wr_accept", rdy, 1'b1);
    if (rdy && track) exp_q.push_back(data);
    @(negedge clk);
  endtask

  task automatic idle_wr(input int sel);
    if (sel == 0) wr_valid_a = 1'b0;
    else          wr_valid_b = 1'b0;
  endtask

  task automatic wait_idle(input int sel);
    int n;
    n = 0;
    while (busy_of(sel) !== 1'b0 && n < 500) begin
      @(negedge clk); n++;
    end
    check("wait_idle", busy_of(sel), 1'b0);
  endtask

  // Receiver: waits lo..hi negedges for a start bit, then samples mid-bit.
  task automatic rx_frame(input int sel, input int nbits, input int par,
                          input int nstop, input int lo, input int hi);
    int n;
    logic [8:0] d, e;
    logic p, pe;
    n = 0;
    d = '0;
    while (txd_of(sel) !== 1'b0 && n <= hi) begin
      @(negedge clk); n++;
    end
    check_range("rx_gap", n, lo, hi);
    if (txd_of(sel) !== 1'b0) return;
    repeat (5) @(negedge clk);
    check("rx_start_bit", txd_of(sel), 1'b0);
    for (int i = 0; i < nbits; i++) begin
      repeat (10) @(negedge clk);
      d[i] = txd_of(sel);
    end
    check_range("rx_queue_depth", exp_q.size(), 1, 64);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h0;
    if (par != 0) begin
      repeat (10) @(negedge clk);
      p = txd_of(sel);
      pe = (par == 2) ? ^e : ~^e;
      check("rx_parity", p, pe);
    end
    for (int s = 0; s < nstop; s++) begin
      repeat (10) @(negedge clk);
      check("rx_stop_bit", txd_of(sel), 1'b1);
    end
    check("rx_data", d, e);
  endtask

  initial begin
    int n;
    logic [8:0] w;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    wr_valid_a = 1'b0; wr_data_a = '0;
    wr_valid_b = 1'b0; wr_data_b = '0;
`ifdef UART_TX_CTS_EN
    cts_n_a = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd_a", txd_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_ready_a", wr_ready_a, 1'b1);
    check("rst_level_a", level_a, 0);
    check("rst_txd_b", txd_b, 1'b1);
    check("rst_busy_b", busy_b, 1'b0);
    check("rst_ready_b", wr_ready_b, 1'b1);
    check("rst_level_b", level_b, 0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5: latency, start-bit length, busy drop
    write_word(0, 9'hA5, 1'b0);
    idle_wr(0);
    n = 0;
    while (txd_a !== 1'b0 && n < 20) begin
      @(negedge clk); n++;
    end
    check("latency_edges", n, 2);
    n = 0;
    while (txd_a === 1'b0 && n < 30) begin
      @(negedge clk); n++;
    end
    check_range("start_bit_len", n, 9, 11);
    n = 0;
    while (busy_a !== 1'b0 && n < 200) begin
      @(negedge clk); n++;
    end
    check_range("busy_fall_delay", n, 80, 100);

    // 8N1 0xA5 decoded bit by bit
    write_word(0, 9'hA5, 1'b1);
    idle_wr(0);
    rx_frame(0, 8, 0, 1, 0, 20);
    check("busy_in_stop", busy_a, 1'b1);
    n = 0;
    while (busy_a !== 1'b0 && n < 20) begin
      @(negedge clk); n++;
    end
    check_range("busy_after_stop", n, 1, 8);

    // 7E2: 0x41 (parity 0) then 0x43 (parity 1), back-to-back
    write_word(1, 9'h41, 1'b1);
    write_word(1, 9'h43, 1'b1);
    idle_wr(1);
    rx_frame(1, 7, 2, 2, 0, 20);
    rx_frame(1, 7, 2, 2, 0, 9);
    wait_idle(1);

    // Depth 4: six writes with wr_valid held; stalls at level 4
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          write_word(1, 9'($urandom_range(0, 127)), 1'b1);
          if (i == 4) begin
            check("full_level", level_b, 4);
            check("full_ready", wr_ready_b, 1'b0);
          end
        end
        idle_wr(1);
      end
      begin
        rx_frame(1, 7, 2, 2, 0, 20);
        for (int i = 1; i < 6; i++) rx_frame(1, 7, 2, 2, 0, 9);
      end
    join
    wait_idle(1);

    // Reset during data bit 3 of 0x00 with one word still queued
    write_word(0, 9'h00, 1'b0);
    write_word(0, 9'h33, 1'b0);
    idle_wr(0);
    n = 0;
    while (txd_a !== 1'b0 && n < 20) begin
      @(negedge clk); n++;
    end
    check_range("abort_start", n, 0, 19);
    repeat (45) @(negedge clk);
    check("pre_reset_txd", txd_a, 1'b0);
    check("pre_reset_level", level_a, 1);
    rst_a_n = 1'b0;
    #1;
    check("reset_txd_async", txd_a, 1'b1);
    check("reset_level", level_a, 0);
    check("reset_busy", busy_a, 1'b0);
    check("reset_ready", wr_ready_a, 1'b1);
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    @(negedge clk);
    write_word(0, 9'h5A, 1'b1);
    idle_wr(0);
    rx_frame(0, 8, 0, 1, 0, 20);
    wait_idle(0);

    // Write coinciding with a STOP->START pop at level 2
    for (int i = 0; i < 3; i++) write_word(0, 9'($urandom_range(0, 255)), 1'b1);
    idle_wr(0);
    fork
      begin
        rx_frame(0, 8, 0, 1, 0, 20);
        for (int i = 1; i < 4; i++) rx_frame(0, 8, 0, 1, 0, 9);
      end
      begin
        n = 0;
        while (dut_a.pop !== 1'b1 && n < 400) begin
          @(negedge clk); n++;
        end
        check_range("pop_found", n, 1, 399);
        check("lvl_before_pop", level_a, 2);
        w = 9'($urandom_range(0, 255));
        wr_valid_a = 1'b1;
        wr_data_a = w[7:0];
        exp_q.push_back(w);
        @(posedge clk);
        @(negedge clk);
        wr_valid_a = 1'b0;
        check("lvl_pop_push", level_a, 2);
      end
    join
    wait_idle(0);

`ifdef UART_TX_CTS_EN
    // CTS gating: blocked frame holds txd high, start 3-4 clk after release
    cts_n_a = 1'b1;
    repeat (5) @(negedge clk);
    write_word(0, 9'h55, 1'b1);
    idle_wr(0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txd_a !== 1'b1) n++;
    end
    check("cts_block_txd", n, 0);
    check("cts_block_busy", busy_a, 1'b1);
    check("cts_block_level", level_a, 1);
    cts_n_a = 1'b0;
    fork
      rx_frame(0, 8, 0, 1, 3, 4);
      begin
        repeat (40) @(negedge clk);
        cts_n_a = 1'b1;
        repeat (30) @(negedge clk);
        cts_n_a = 1'b0;
      end
    join
    wait_idle(0);
`endif

    check("exp_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
